disp_capture: RTL
=================

Name: disp_capture

Overview:
- Reader for the multiplexed 7-segment display bus (common/segment) driven by the display block.
- Samples the strobed digit positions, decodes each segment pattern back to a 4-bit hex code and rebuilds the five-digit frame (dig4..dig0 plus per-digit enable).
- Used as an on-chip self-check / loopback monitor of the lock's display path and as the source for a remote display mirror.

Parameters:
- STABLE_CYC, 4: consecutive identical samples required before a digit position is accepted (legal range 1..255).
- TIMEOUT_CYC, 4096: cycles without any accepted digit before the frame is declared stale (legal range 2..2^20).

Ports:
- ck  input  1  system clock.
- resetn  input  1  reset; synchronous, active-low.
- common  input  5  digit select from display; active-high, expected one-hot; bit4 = dig4.
- segment  input  7  segment lines; active-high; bit0 = a … bit6 = g.
- dig4, dig3, dig2, dig1, dig0  output  4 each  decoded digit codes.
- dispen  output  5  1 = position shows a decoded glyph; 0 = blank or undecodable.
- frame_valid  output  1  one-cycle pulse when all five positions have been accepted since the last pulse.
- changed  output  1  one-cycle pulse, coincident with frame_valid, when any dig/dispen value differs from the previous frame.
- ghost  output  1  sticky; set when more than one common bit is seen active; cleared only by reset.
- decerr  output  1  one-cycle pulse when an accepted non-blank pattern is not in the decode table.
- stale  output  1  high while no digit has been accepted for TIMEOUT_CYC cycles.

Behaviour:
- Reset (resetn = 0 at a ck edge): all outputs 0, seen mask 0, FSM in IDLE, all counters 0, input register 0. Reset mid-capture discards the partial frame.
- Input stage: common and segment are registered once. All decisions use the registered values, so there is 1 cycle of input latency.
- Classification of registered common: zero bits set = gap; exactly one bit set = strobe; two or more bits set = ghost (ghost is set and the sample is treated as a gap).
- FSM:
  - IDLE: gap → stay. Strobe → TRACK, stable count = 1, latch (common, segment).
  - TRACK: sample equal to latch → count+1. Strobe with a different value → relatch, count = 1. Gap → IDLE. When count reaches STABLE_CYC, the position is accepted in that same cycle → HOLD. With STABLE_CYC = 1, the position is accepted on the first strobe cycle.
  - HOLD: sample equal to latch → stay, no re-accept. Any other value → handled exactly as from IDLE.
- Accept on position p:
  - Segment 7'h00: dig_p = 0, dispen[p] = 0.
  - Table match: dig_p = code, dispen[p] = 1. Table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - No match: dig_p = 4'hF, dispen[p] = 0, decerr pulses.
  - In all three cases seen[p] is set.
- dig/dispen registers update 1 cycle after the accept decision. Positions not accepted keep their previous values.
- Frame completion:
  - When seen becomes 5'h1F: frame_valid pulses in the cycle after the final update, and seen clears to 0.
  - changed compares against a snapshot taken at the previous frame_valid. The first frame after reset always asserts changed.
- Simultaneous events: an accept that sets the final seen bit counts toward the current frame. A new accept arriving in the clear cycle counts toward the next frame.
- Timeout counter:
  - Counter increments every cycle with no accept, saturating at TIMEOUT_CYC. Any accept clears it to 0.
  - stale = (counter == TIMEOUT_CYC). Reaching stale also clears seen.
  - dig/dispen hold their last values while stale.

Optional Feature:
- Macro DISP_CAPTURE_ACTLOW_EN.
- Defined: common and segment are inverted in the input stage (active-low display bus). An all-ones input is therefore a gap/blank. All other behaviour is unchanged.
- Undefined: active-high, as specified above.

Test Plan:
- Reset: hold resetn = 0 with common = 5'h04, segment = 7'h06 → all outputs 0; after release, no accept before STABLE_CYC + 1 cycles.
- Full frame: STABLE_CYC = 4; drive positions 4..0 each for 8 cycles with 2-cycle gaps, patterns 06, 5B, 4F, 66, 6D → dig4..0 = 1, 2, 3, 4, 5, dispen = 1F, one frame_valid pulse with changed = 1. Repeat the same frame → frame_valid with changed = 0.
- Glitch/stability: 3 cycles of 3F then 1 cycle of 06 then gap → no accept. 4 cycles of 3F → accept dig = 0.
- Blank and bad pattern: segment 00 on pos2 → dispen[2] = 0, dig2 = 0. Segment 7'h55 on pos1 → decerr pulse, dig1 = F, dispen[1] = 0.
- Ghost: common = 5'h03 for 10 cycles → ghost = 1 and sticky, no accept.
- Timeout: TIMEOUT_CYC = 16; idle inputs after one accept → stale rises exactly 16 cycles after the accept, and the next accept clears it.

Source files
------------

// File: rtl/disp_capture.sv
// rtl/disp_capture.sv - 7-segment display bus reader rebuilding the five-digit frame; DISP_CAPTURE_ACTLOW_EN selects an active-low bus
module disp_capture #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       ck,
    input  logic       resetn,
    input  logic [4:0] common,
    input  logic [6:0] segment,
    output logic [3:0] dig4,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic [4:0] dispen,
    output logic       frame_valid,
    output logic       changed,
    output logic       ghost,
    output logic       decerr,
    output logic       stale
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
    localparam logic [7:0] SMAX = 8'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t          state, state_nx;
    logic [4:0]      com_r, com_l, com_l_nx;
    logic [6:0]      seg_r, seg_l, seg_l_nx;
    logic [7:0]      cnt, cnt_nx;
    logic            acc;
    logic [4:0][3:0] digs, snap_digs;
    logic [4:0]      snap_en;
    logic [4:0]      seen;
    logic            first;
    logic [TW-1:0]   tcnt;
    logic            multi, strobe, same;
    logic [4:0]      dec;

    // Returns {hit, code}; the blank pattern deliberately misses.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_ff @(posedge ck) begin
        if (!resetn) begin
            com_r <= '0;
            seg_r <= '0;
        end else begin
`ifdef DISP_CAPTURE_ACTLOW_EN
            com_r <= ~common;
            seg_r <= ~segment;
`else
            com_r <= common;
            seg_r <= segment;
`endif
        end
    end

    assign multi  = |(com_r & (com_r - 5'd1));
    assign strobe = (|com_r) && !multi;
    assign same   = (com_r == com_l) && (seg_r == seg_l);
    assign dec    = decode(seg_r);

    always_comb begin
        state_nx = state;
        com_l_nx = com_l;
        seg_l_nx = seg_l;
        cnt_nx   = cnt;
        acc      = 1'b0;
        if (state == TRACK && strobe && same) begin
            cnt_nx = cnt + 8'd1;
            if (cnt_nx == SMAX) begin
                acc      = 1'b1;
                state_nx = HOLD;
            end
        end else if (state == HOLD && strobe && same) begin
            state_nx = HOLD;
        end else if (strobe) begin
            // A fresh strobe restarts tracking; with a threshold of 1 it is accepted at once.
            com_l_nx = com_r;
            seg_l_nx = seg_r;
            cnt_nx   = 8'd1;
            acc      = (SMAX == 8'd1);
            state_nx = (SMAX == 8'd1) ? HOLD : TRACK;
        end else begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge ck) begin
        if (!resetn) begin
            state       <= IDLE;
            com_l       <= '0;
            seg_l       <= '0;
            cnt         <= '0;
            digs        <= '0;
            dispen      <= '0;
            snap_digs   <= '0;
            snap_en     <= '0;
            seen        <= '0;
            first       <= 1'b1;
            tcnt        <= '0;
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            ghost       <= 1'b0;
            decerr      <= 1'b0;
        end else begin
            state  <= state_nx;
            com_l  <= com_l_nx;
            seg_l  <= seg_l_nx;
            cnt    <= cnt_nx;
            ghost  <= ghost | multi;
            decerr <= acc && (seg_r != 7'h00) && !dec[4];
            for (int p = 0; p < 5; p++) begin
                if (acc && com_r[p]) begin
                    digs[p]   <= dec[4] ? dec[3:0] : ((seg_r == 7'h00) ? 4'h0 : 4'hF);
                    dispen[p] <= dec[4];
                end
            end
            if (acc)
                tcnt <= '0;
            else if (tcnt != TMAX)
                tcnt <= tcnt + TW'(1);
            frame_valid <= (seen == 5'h1F);
            changed     <= (seen == 5'h1F) && (first || (digs != snap_digs) || (dispen != snap_en));
            if (seen == 5'h1F) begin
                snap_digs <= digs;
                snap_en   <= dispen;
                first     <= 1'b0;
            end
            // An accept landing in the clear cycle seeds the next frame.
            seen <= (((seen == 5'h1F) || stale) ? 5'h00 : seen) | (acc ? com_r : 5'h00);
        end
    end

    assign stale = (tcnt == TMAX);
    assign dig4  = digs[4];
    assign dig3  = digs[3];
    assign dig2  = digs[2];
    assign dig1  = digs[1];
    assign dig0  = digs[0];

endmodule
